// File: rtl/i2s_mic_rx.sv
// I2S capture from the codec ADC path: oversamples bclk/lrclk/adcdat in the clk domain and
// delivers left/right pairs over a valid/ready handshake, with alignment, lock and overflow status.
module i2s_mic_rx #(
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                bclk,
    input  logic                lrclk,
    input  logic                adcdat,
    input  logic                out_ready,
    input  logic                ovf_clr,
    output logic                out_valid,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic                overflow,
    output logic                frame_err,
    output logic                locked
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {ALIGN, DELAY, SHIFT, HOLD} state_t;

    logic [1:0]             rst_sync_q;
    logic                   rst_n;
    logic [SYNC_STAGES-1:0] bclk_sync_q, lr_sync_q, dat_sync_q;
    logic                   bclk_s, lr_s, dat_s, bclk_last_q, brise, lr_edge, timeout;

    state_t                 state_q, state_d;
    logic [SAMPLE_W-2:0]    sr_q, sr_d;
    logic [SAMPLE_W-1:0]    word;
    logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
    logic                   slot_lr_q, slot_lr_d;
    logic                   lr_last_q, lr_last_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [SAMPLE_W-1:0]    pend_left_q, pend_left_d;
    logic                   pair_fire;
    logic                   out_valid_q, out_valid_d;
    logic [SAMPLE_W-1:0]    out_left_q, out_left_d, out_right_q, out_right_d;
    logic                   overflow_q, overflow_d;
    logic                   frame_err_q, frame_err_d;
    logic                   locked_q, locked_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;

    // Reset asserts asynchronously but releases only after two clk edges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rst_sync_q <= '0;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            dat_sync_q  <= '0;
            bclk_last_q <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
            lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], lrclk};
            dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], adcdat};
            bclk_last_q <= bclk_s;
        end
    end

    assign bclk_s  = bclk_sync_q[SYNC_STAGES-1];
    assign lr_s    = lr_sync_q[SYNC_STAGES-1];
    assign dat_s   = dat_sync_q[SYNC_STAGES-1];
    assign brise   = bclk_s & ~bclk_last_q;
    assign lr_edge = lr_s ^ lr_last_q;
    assign word    = {sr_q, dat_s};
    assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYC));

    // Slot tracking: the brise that reveals an lr change is the I2S delay bit, so the
    // MSB is captured on the following brise while leaving DELAY.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bitcnt_d     = bitcnt_q;
        slot_lr_d    = slot_lr_q;
        lr_last_d    = lr_last_q;
        pend_valid_d = pend_valid_q;
        pend_left_d  = pend_left_q;
        frame_err_d  = 1'b0;
        pair_fire    = 1'b0;
        if (brise) begin
            lr_last_d = lr_s;
            case (state_q)
                ALIGN: begin
                    if (lr_edge && !lr_s) begin
                        state_d   = DELAY;
                        slot_lr_d = 1'b0;
                        bitcnt_d  = '0;
                    end
                end
                DELAY, SHIFT: begin
                    if (lr_edge) begin
                        frame_err_d  = 1'b1;
                        pend_valid_d = 1'b0;
                        slot_lr_d    = lr_s;
                        bitcnt_d     = '0;
                        state_d      = lr_s ? ALIGN : DELAY;
                    end else begin
                        sr_d     = word[SAMPLE_W-2:0];
                        bitcnt_d = (state_q == DELAY) ? CNT_W'(1) : bitcnt_q + CNT_W'(1);
                        state_d  = SHIFT;
                        if (state_q == SHIFT && bitcnt_q == CNT_W'(SAMPLE_W - 1)) begin
                            state_d = HOLD;
                            if (!slot_lr_q) begin
                                pend_left_d  = word;
                                pend_valid_d = 1'b1;
                            end else begin
                                pair_fire    = pend_valid_q;
                                pend_valid_d = 1'b0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (lr_edge) begin
                        state_d   = DELAY;
                        slot_lr_d = lr_s;
                        bitcnt_d  = '0;
                    end
                end
                default: state_d = ALIGN;
            endcase
        end
        if (timeout) begin
            state_d      = ALIGN;
            pend_valid_d = 1'b0;
        end
    end

    // Output holding register, sticky overflow, lock and bclk-loss watchdog.
    always_comb begin
        out_valid_d = out_valid_q;
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        overflow_d  = overflow_q;
        locked_d    = locked_q;
        to_cnt_d    = to_cnt_q;
        if (ovf_clr)
            overflow_d = 1'b0;
        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
        if (pair_fire) begin
            locked_d = 1'b1;
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_left_d  = pend_left_q;
                out_right_d = word;
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (brise)
            to_cnt_d = '0;
        else if (!timeout)
            to_cnt_d = to_cnt_q + TO_W'(1);
        if (timeout)
            locked_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ALIGN;
            sr_q         <= '0;
            bitcnt_q     <= '0;
            slot_lr_q    <= 1'b0;
            lr_last_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_left_q  <= '0;
            out_valid_q  <= 1'b0;
            out_left_q   <= '0;
            out_right_q  <= '0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            locked_q     <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bitcnt_q     <= bitcnt_d;
            slot_lr_q    <= slot_lr_d;
            lr_last_q    <= lr_last_d;
            pend_valid_q <= pend_valid_d;
            pend_left_q  <= pend_left_d;
            out_valid_q  <= out_valid_d;
            out_left_q   <= out_left_d;
            out_right_q  <= out_right_d;
            overflow_q   <= overflow_d;
            frame_err_q  <= frame_err_d;
            locked_q     <= locked_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Scoreboard bench for i2s_mic_rx: a codec BFM drives I2S frames, expected pairs are queued at
// issue time and a handshake monitor pops and compares them.
module tb_i2s_mic_rx;

    localparam int W         = 16;
    localparam int SYNC      = 2;
    localparam int HALF_BCLK = 3;
    localparam int SLOT      = 32;

    logic         clk = 1'b0, resetn = 1'b0, bclk = 1'b0, lrclk = 1'b1, adcdat = 1'b0;
    logic         out_ready = 1'b1, ovf_clr = 1'b0;
    logic         out_valid, overflow, frame_err, locked;
    logic [W-1:0] out_left, out_right;

    int checks = 0, failures = 0;
    int cyc = 0, lsbCyc = 0, riseCyc = -1;
    int frameErrCnt = 0, popCnt = 0;
    logic prevValid = 1'b0;
    logic [2*W-1:0] expQ[$];

    i2s_mic_rx #(.SAMPLE_W(W), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(256)) dut (
        .clk(clk), .resetn(resetn), .bclk(bclk), .lrclk(lrclk), .adcdat(adcdat),
        .out_ready(out_ready), .ovf_clr(ovf_clr), .out_valid(out_valid),
        .out_left(out_left), .out_right(out_right), .overflow(overflow),
        .frame_err(frame_err), .locked(locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Codec BFM: bit j of a slot; j=0 is the delay bit, j=1..W the word MSB first, the rest random padding.
    task automatic sendBits(input logic lr, input logic [W-1:0] wordIn, input int first, input int count);
        for (int j = first; j < first + count; j++) begin
            bclk   = 1'b0;
            lrclk  = lr;
            adcdat = (j >= 1 && j <= W) ? wordIn[W-j] : 1'($urandom_range(0, 1));
            tick(HALF_BCLK);
            bclk = 1'b1;
            if (j == W) lsbCyc = cyc;
            tick(HALF_BCLK);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] l, input logic [W-1:0] r, input bit expectPair);
        if (expectPair) expQ.push_back({l, r});
        sendBits(1'b0, l, 0, SLOT);
        sendBits(1'b1, r, 0, SLOT);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 200 && expQ.size() != 0; k++) tick(1);
        checkOutput(name, 32'(expQ.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (frame_err === 1'b1) frameErrCnt++;
        if (out_valid === 1'b1 && prevValid !== 1'b1) riseCyc = cyc;
        prevValid = out_valid;
        if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            popCnt++;
            checkOutput("pair_expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) checkOutput("pair_value", {out_left, out_right}, expQ.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] lBase, rBase, l1, r1, la, ra, lc, rc;

        tick(3);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_pair", {out_left, out_right}, 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset_locked", 32'(locked), 32'd0);
        resetn = 1'b1;
        tick(5);

        $display("[TB] basic frame");
        sendBits(1'b1, '0, 0, SLOT);
        applyStimulus(16'h8001, 16'h7FFE, 1'b1);
        drain("t1_drain");
        checkOutput("t1_locked", 32'(locked), 32'd1);
        checkOutput("t1_latency", 32'(riseCyc - lsbCyc), 32'(SYNC + 1));

        $display("[TB] streaming frames");
        lBase = 16'($urandom);
        rBase = 16'($urandom);
        for (int i = 0; i < 100; i++) applyStimulus(lBase + 16'(i), rBase + 16'(i), 1'b1);
        drain("t2_drain");
        checkOutput("t2_overflow", 32'(overflow), 32'd0);
        checkOutput("t2_frame_err", 32'(frameErrCnt), 32'd0);
        checkOutput("t2_pops", 32'(popCnt), 32'd101);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        l1 = 16'($urandom);
        r1 = 16'($urandom);
        applyStimulus(l1, r1, 1'b1);
        applyStimulus(16'($urandom), 16'($urandom), 1'b0);
        applyStimulus(16'($urandom), 16'($urandom), 1'b0);
        checkOutput("t3_valid_held", 32'(out_valid), 32'd1);
        checkOutput("t3_pair_held", {out_left, out_right}, {l1, r1});
        checkOutput("t3_overflow", 32'(overflow), 32'd1);
        ovf_clr   = 1'b1;
        out_ready = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        tick(1);
        checkOutput("t3_ovf_cleared", 32'(overflow), 32'd0);
        drain("t3_drain_held");
        applyStimulus(16'($urandom), 16'($urandom), 1'b1);
        drain("t3_drain_next");

        $display("[TB] truncated right slot");
        sendBits(1'b0, 16'($urandom), 0, SLOT);
        sendBits(1'b1, 16'($urandom), 0, 10);
        applyStimulus(16'($urandom), 16'($urandom), 1'b1);
        drain("t4_drain");
        checkOutput("t4_frame_err", 32'(frameErrCnt), 32'd1);

        $display("[TB] bclk loss");
        lc = 16'($urandom);
        rc = 16'($urandom);
        sendBits(1'b0, lc, 0, SLOT);
        sendBits(1'b1, rc, 0, 8);
        bclk = 1'b0;
        tick(300);
        checkOutput("t5_unlocked", 32'(locked), 32'd0);
        sendBits(1'b1, rc, 8, SLOT - 8);
        applyStimulus(16'($urandom), 16'($urandom), 1'b1);
        drain("t5_drain");
        checkOutput("t5_relocked", 32'(locked), 32'd1);

        $display("[TB] reset mid-shift");
        out_ready = 1'b0;
        la = 16'($urandom);
        ra = 16'($urandom);
        applyStimulus(la, ra, 1'b0);
        applyStimulus(16'($urandom), 16'($urandom), 1'b0);
        sendBits(1'b0, lc, 0, SLOT);
        sendBits(1'b1, rc, 0, 8);
        checkOutput("t6_pre_pair", {out_left, out_right}, {la, ra});
        checkOutput("t6_pre_overflow", 32'(overflow), 32'd1);
        resetn = 1'b0;
        #2;
        checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_rst_pair", {out_left, out_right}, 32'd0);
        checkOutput("t6_rst_overflow", 32'(overflow), 32'd0);
        checkOutput("t6_rst_locked", 32'(locked), 32'd0);
        tick(3);
        resetn    = 1'b1;
        out_ready = 1'b1;
        tick(3);
        sendBits(1'b1, rc, 8, SLOT - 8);
        applyStimulus(16'($urandom), 16'($urandom), 1'b1);
        drain("t6_drain");
        checkOutput("t6_locked", 32'(locked), 32'd1);

        tick(20);
        checkOutput("total_pops", 32'(popCnt), 32'd106);
        checkOutput("total_frame_err", 32'(frameErrCnt), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
